// File: rtl/mem_io_bridge_if.sv
// CPU-side byte bus between the core and the memory/IO bridge.
// Signal suffixes are from the bridge's point of view.
interface mem_io_bridge_if;
  logic [31:0] cpu_a_i;
  logic [7:0]  cpu_dout_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_din_o;

  modport master (output cpu_a_i, output cpu_dout_i, output cpu_wr_i, input cpu_din_o);
  modport slave  (input cpu_a_i, input cpu_dout_i, input cpu_wr_i, output cpu_din_o);
endinterface

// File: rtl/mem_io_bridge.sv
// Routes CPU byte accesses to RAM or memory-mapped IO with one-cycle read return;
// owns the UART TX FIFO, the free-running cycle counter and the sticky program-stop flag.
module mem_io_bridge #(
  parameter int TX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2,
  parameter int RAM_ADR_W    = 17
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_bridge_if.slave       cpu,
  output logic                 io_buffer_full_o,
  output logic [RAM_ADR_W-1:0] ram_a_o,
  output logic [7:0]           ram_dat_o,
  output logic                 ram_wr_o,
  input  logic [7:0]           ram_dat_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_pop_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 program_stop_o
);
  localparam int DEPTH = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0]   DEPTH_C = DEPTH[TX_DEPTH_LOG:0];
  localparam logic [TX_DEPTH_LOG:0]   FULL_TH = DEPTH_C - FULL_MARGIN[TX_DEPTH_LOG:0];
  localparam logic [TX_DEPTH_LOG:0]   CNT_ONE = 1;
  localparam logic [TX_DEPTH_LOG-1:0] PTR_ONE = 1;

  logic                    sel_q;
  logic [7:0]              io_rd_q, io_rd_d;
  logic [31:0]             snap_q, snap_d;
  logic [31:0]             cnt_q;
  logic                    stop_q;
  logic [TX_DEPTH_LOG-1:0] head_q, tail_q;
  logic [TX_DEPTH_LOG:0]   count_q, count_d;
  logic                    full_q;
  logic [7:0]              mem_q [DEPTH];

  logic        is_io, rd_io, wr_io, push_req, push, pop, set_stop;
  logic [15:0] io_off;
  logic [7:0]  push_dat;
  logic        unused_a;

  assign is_io    = (cpu.cpu_a_i[17:16] == 2'b11);
  assign io_off   = cpu.cpu_a_i[15:0];
  assign rd_io    = is_io && !cpu.cpu_wr_i;
  assign wr_io    = is_io && cpu.cpu_wr_i;
  assign unused_a = ^cpu.cpu_a_i[31:18];

  assign ram_a_o   = cpu.cpu_a_i[RAM_ADR_W-1:0];
  assign ram_dat_o = cpu.cpu_dout_i;
  assign ram_wr_o  = cpu.cpu_wr_i && !is_io;

  assign cpu.cpu_din_o = sel_q ? io_rd_q : ram_dat_i;
  assign rx_pop_o      = !rst_in && rd_io && (io_off == 16'h0000) && rx_valid_i;

  // 0x30004 writes queue a 0x00 terminator; once stopped nothing more is queued.
  assign set_stop = !rst_in && wr_io && (io_off == 16'h0004);
  assign push_req = !rst_in && !stop_q && wr_io &&
                    (((io_off == 16'h0000) && (cpu.cpu_dout_i != 8'h00)) || (io_off == 16'h0004));
  assign push_dat = (io_off == 16'h0004) ? 8'h00 : cpu.cpu_dout_i;
  assign pop      = !rst_in && (count_q != '0) && tx_ready_i;
  assign push     = push_req && ((count_q != DEPTH_C) || pop);

  assign tx_valid_o       = (count_q != '0);
  assign tx_data_o        = tx_valid_o ? mem_q[head_q] : 8'h00;
  assign io_buffer_full_o = full_q;
  assign program_stop_o   = stop_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // Reading byte 0 of the counter freezes it so bytes 1..3 read back coherently.
  always_comb begin
    io_rd_d = io_rd_q;
    snap_d  = snap_q;
    if (rd_io) begin
      case (io_off)
        16'h0000: io_rd_d = rx_valid_i ? rx_data_i : 8'h00;
        16'h0004: begin
          io_rd_d = cnt_q[7:0];
          snap_d  = cnt_q;
        end
        16'h0005: io_rd_d = snap_q[15:8];
        16'h0006: io_rd_d = snap_q[23:16];
        16'h0007: io_rd_d = snap_q[31:24];
        default:  io_rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q   <= 1'b0;
      io_rd_q <= 8'h00;
      snap_q  <= 32'h0;
      cnt_q   <= 32'h0;
      stop_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      sel_q   <= is_io;
      io_rd_q <= io_rd_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_q + 32'd1;
      if (set_stop) stop_q <= 1'b1;
      if (push)     tail_q <= tail_q + PTR_ONE;
      if (pop)      head_q <= head_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d >= FULL_TH);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[tail_q] <= push_dat;
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: one request per cycle, read data and TX bytes
// predicted from a behavioural model and compared as the DUT returns them.
module tb_mem_io_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        io_buffer_full_o;
  logic [16:0] ram_a_o;
  logic [7:0]  ram_dat_o;
  logic        ram_wr_o;
  logic [7:0]  ram_q;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready;
  logic        program_stop_o;

  mem_io_bridge_if bus ();

  mem_io_bridge #(.TX_DEPTH_LOG(4), .FULL_MARGIN(2), .RAM_ADR_W(17)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .cpu              (bus),
    .io_buffer_full_o (io_buffer_full_o),
    .ram_a_o          (ram_a_o),
    .ram_dat_o        (ram_dat_o),
    .ram_wr_o         (ram_wr_o),
    .ram_dat_i        (ram_q),
    .rx_valid_i       (rx_valid),
    .rx_data_i        (rx_data),
    .rx_pop_o         (rx_pop_o),
    .tx_valid_o       (tx_valid_o),
    .tx_data_o        (tx_data_o),
    .tx_ready_i       (tx_ready),
    .program_stop_o   (program_stop_o)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk) begin
    if (ram_wr_o) ram_mem[ram_a_o] <= ram_dat_o;
    ram_q <= ram_mem[ram_a_o];
  end

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  exp_ram [logic [16:0]];
  logic [7:0]  rd_sb [$];
  logic [7:0]  tx_sb [$];
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] snap_m  = 32'h0;
  logic        stop_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One CPU request: drive, predict, clock, compare.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic        io;
    logic [15:0] off;
    logic [16:0] ra;
    logic        rd_chk;
    logic [7:0]  rd_exp;
    bus.cpu_a_i    = a;
    bus.cpu_dout_i = d;
    bus.cpu_wr_i   = wr;
    #1;
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    ra  = a[16:0];
    check("ram_wr", ram_wr_o, wr && !io);
    check("rx_pop", rx_pop_o, !rst && io && !wr && (off == 16'h0) && rx_valid);
    rd_chk = 1'b0;
    rd_exp = 8'h00;
    if (!wr) begin
      if (io && !rst) begin
        rd_chk = 1'b1;
        if (off == 16'h0)      rd_exp = rx_valid ? rx_data : 8'h00;
        else if (off == 16'h4) begin rd_exp = exp_cnt[7:0]; snap_m = exp_cnt; end
        else if (off == 16'h5) rd_exp = snap_m[15:8];
        else if (off == 16'h6) rd_exp = snap_m[23:16];
        else if (off == 16'h7) rd_exp = snap_m[31:24];
      end else if (exp_ram.exists(ra)) begin
        rd_chk = 1'b1;
        rd_exp = exp_ram[ra];
      end
    end
    if (rd_chk) rd_sb.push_back(rd_exp);
    if (wr && !io) exp_ram[ra] = d;
    if (!rst && tx_ready && tx_sb.size() != 0) begin
      check("tx_dat", tx_data_o, tx_sb[0]);
      void'(tx_sb.pop_front());
    end
    if (!rst && !stop_m && wr && io && (((off == 16'h0) && (d != 8'h00)) || (off == 16'h4)))
      if (tx_sb.size() < 16) tx_sb.push_back((off == 16'h4) ? 8'h00 : d);
    if (!rst && wr && io && (off == 16'h4)) stop_m = 1'b1;
    @(posedge clk);
    if (rst) begin
      exp_cnt = 32'h0;
      snap_m  = 32'h0;
      stop_m  = 1'b0;
      tx_sb.delete();
    end else begin
      exp_cnt = exp_cnt + 32'd1;
    end
    #1;
    if (rd_chk) check("rd_dat", bus.cpu_din_o, rd_sb.pop_front());
    check("tx_vld", tx_valid_o, tx_sb.size() != 0);
    check("full", io_buffer_full_o, tx_sb.size() >= 14);
    check("stop", program_stop_o, stop_m);
  endtask

  initial begin
    rst = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    bus.cpu_a_i = 32'h0;
    bus.cpu_dout_i = 8'h00;
    bus.cpu_wr_i = 1'b0;
    @(posedge clk);
    #1;
    cyc(32'h0, 1'b0, 8'h00);
    cyc(32'h0, 1'b0, 8'h00);
    rst = 1'b0;
    check("rst_tx_dat", tx_data_o, 8'h00);
    check("rst_tx_vld", tx_valid_o, 1'b0);
    check("rst_full", io_buffer_full_o, 1'b0);
    check("rst_stop", program_stop_o, 1'b0);

    // RAM write then read back
    cyc(32'h0000_0100, 1'b1, 8'hA5);
    cyc(32'h0000_0100, 1'b0, 8'h00);
    cyc(32'h0000_0100, 1'b0, 8'h00);

    // TX: zero data is not queued, then drain in order
    cyc(32'h0003_0000, 1'b1, 8'h41);
    cyc(32'h0003_0000, 1'b1, 8'h00);
    cyc(32'h0003_0000, 1'b1, 8'h42);
    check("tx_head", tx_data_o, 8'h41);
    tx_ready = 1'b1;
    repeat (3) cyc(32'h0000_0100, 1'b0, 8'h00);
    tx_ready = 1'b0;

    // Fill to the almost-full threshold, saturate, push-at-full with pop, drain
    for (int i = 0; i < 14; i++) cyc(32'h0003_0000, 1'b1, 8'(8'h10 + i));
    for (int i = 0; i < 3; i++)  cyc(32'h0003_0000, 1'b1, 8'(8'h20 + i));
    check("sat_head", tx_data_o, 8'h10);
    tx_ready = 1'b1;
    cyc(32'h0003_0000, 1'b1, 8'h30);
    repeat (17) cyc(32'h0000_0100, 1'b0, 8'h00);
    tx_ready = 1'b0;

    // Counter snapshot across four consecutive reads
    repeat (300) cyc(32'h0000_0100, 1'b0, 8'h00);
    cyc(32'h0003_0004, 1'b0, 8'h00);
    cyc(32'h0003_0005, 1'b0, 8'h00);
    cyc(32'h0003_0006, 1'b0, 8'h00);
    cyc(32'h0003_0007, 1'b0, 8'h00);
    cyc(32'h0003_0008, 1'b0, 8'h00);

    // RX read with and without a byte pending; ignored IO write
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    cyc(32'h0003_0000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    rx_data  = 8'h77;
    cyc(32'h0003_0000, 1'b0, 8'h00);
    cyc(32'h0003_0001, 1'b1, 8'h66);

    // Program stop, post-stop push ignored, reset clears everything
    cyc(32'h0001_0004, 1'b1, 8'h5C);
    cyc(32'h0003_0004, 1'b1, 8'h00);
    cyc(32'h0003_0000, 1'b1, 8'h55);
    check("stop_head", tx_data_o, 8'h00);
    rst = 1'b1;
    cyc(32'h0003_0004, 1'b0, 8'h00);
    rst = 1'b0;
    cyc(32'h0000_0100, 1'b0, 8'h00);
    check("post_rst_tx_dat", tx_data_o, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU memory bus (mem_a/mem_dout/mem_wr/mem_din) and upstream of the 128KB RAM and the UART.
- Decodes each byte access to RAM or to memory-mapped I/O, and returns read data with the fixed one-cycle latency the CPU expects.
- Owns the TX FIFO that drives io_buffer_full, the cycle counter at 0x30004, and the program-stop flag.

Parameters:
- TX_DEPTH_LOG, 4, log2 of TX FIFO entries (default 16).
- FULL_MARGIN, 2, free-entry headroom at which io_buffer_full_o asserts.
- RAM_ADR_W, 17, RAM address width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- cpu_a_i  input  32  CPU byte address (mem_a).
- cpu_dout_i  input  8  CPU write data (mem_dout).
- cpu_wr_i  input  1  1 = write, 0 = read (mem_wr).
- cpu_din_o  output  8  read data to CPU (mem_din), valid the cycle after the request.
- io_buffer_full_o  output  1  TX FIFO almost full.
- ram_a_o  output  RAM_ADR_W  RAM address.
- ram_dat_o  output  8  RAM write data.
- ram_wr_o  output  1  RAM write enable.
- ram_dat_i  input  8  RAM read data, one-cycle latency.
- rx_valid_i  input  1  UART RX byte available.
- rx_data_i  input  8  UART RX byte.
- rx_pop_o  output  1  one-cycle pulse that consumes the RX byte.
- tx_valid_o  output  1  TX FIFO non-empty.
- tx_data_o  output  8  TX FIFO head byte.
- tx_ready_i  input  1  UART accepts head byte this cycle.
- program_stop_o  output  1  sticky; program has written 0x30004.

Behaviour:
- Clock and reset: single clock clk_in. Reset rst_in is synchronous and active-high.
- Reset state:
  - TX FIFO empty (head = tail = count = 0).
  - cycle counter = 0, snapshot = 0, program_stop_o = 0.
  - sel_q = RAM, io_rd_q = 0x00, rx_pop_o = 0.
  - Resulting outputs: tx_valid_o = 0, tx_data_o = 0x00, io_buffer_full_o = 0, cpu_din_o = ram_dat_i.
- Decode: is_io = (cpu_a_i[17:16] == 2'b11); otherwise the access targets RAM.
- RAM path (combinational):
  - ram_a_o = cpu_a_i[RAM_ADR_W-1:0], ram_dat_o = cpu_dout_i.
  - ram_wr_o = cpu_wr_i & !is_io. I/O accesses must never write RAM.
- Read return:
  - sel_q <= is_io on every cycle.
  - cpu_din_o = sel_q ? io_rd_q : ram_dat_i. Latency is exactly 1 cycle for both RAM and I/O.
- I/O reads (cpu_wr_i = 0), io_rd_q <= :
  - 0x30000: rx_data_i if rx_valid_i, and rx_pop_o = 1 the same cycle; else 0x00 and no pop.
  - 0x30004: snapshot <= counter; returns counter[7:0].
  - 0x30005..0x30007: snapshot bytes 1..3 (little-endian), so a 4-byte read sequence is coherent.
  - Any other I/O address: 0x00.
- I/O writes (cpu_wr_i = 1):
  - 0x30000 with data != 0x00: push the data byte. Data 0x00 is ignored.
  - 0x30004: set program_stop_o and push 0x00 (the terminator).
  - Any other I/O address: ignored.
  - While program_stop_o = 1, all further pushes are ignored.
  - A push when count == 2^TX_DEPTH_LOG is dropped; FIFO state is unchanged.
- Cycle counter: 32-bit, +1 every non-reset cycle, wraps 0xFFFFFFFF -> 0.
- TX drain:
  - tx_valid_o = (count != 0), tx_data_o = mem[head].
  - Pop when tx_valid_o & tx_ready_i; head wraps modulo depth.
- Simultaneous push and pop: both happen and count is unchanged. This holds even at full, where the push is accepted because a pop occurs in the same cycle.
- io_buffer_full_o = (count >= 2^TX_DEPTH_LOG - FULL_MARGIN), registered from next-state count.
- Reset mid-operation: all state returns to reset values the next edge and FIFO contents are discarded. A read in flight on the reset cycle returns RAM data.

Test Plan:
- Write RAM 0x00100 = 0xA5, then read 0x00100 -> ram_wr_o = 1 only on the write; cpu_din_o = 0xA5 exactly one cycle after the read.
- Write 0x30000 with 0x41, 0x00, 0x42 and tx_ready_i = 0 -> count = 2, tx_data_o = 0x41. Raise tx_ready_i -> tx_data_o sequence 0x41, 0x42, then tx_valid_o = 0.
- Push 14 bytes with tx_ready_i = 0 -> io_buffer_full_o = 1 at count 14. Then push 3 more -> count saturates at 16, the 17th byte is dropped, FIFO order is preserved.
- Counter at 0x12345678, read 0x30004..0x30007 on consecutive cycles -> cpu_din_o = 0x78, 0x56, 0x34, 0x12 despite the counter advancing.
- rx_valid_i = 1 with 0x33, read 0x30000 -> rx_pop_o pulses for 1 cycle and cpu_din_o = 0x33. With rx_valid_i = 0 -> cpu_din_o = 0x00 and no pop.
- Write 0x30004 -> program_stop_o = 1 and 0x00 is queued. A subsequent 0x30000 write of 0x55 is ignored. Assert rst_in -> program_stop_o = 0 and the FIFO is empty.
